pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_stall_ctrl_sat_counter32.sv | 26 ++
 rtl/pipe_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipe_ctrl_pkg;

  // Default width of the multi-cycle mul/div occupancy count.
  localparam int MD_CNT_W_DEFAULT = 6;

  // Controller states:
  //   RUN     - pipeline flowing; single-cycle hazards are handled here
  //   LSTALL  - second bubble cycle of a load feeding a branch/jump in ID
  //   MD_WAIT - mul/div still occupying EX; front end frozen
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LSTALL  = 2'd1,
    MD_WAIT = 2'd2
  } stall_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter32.sv
// Enable-driven 32-bit counter that holds at all-ones instead of wrapping.
// Only compiled when STALL_PERF_CNT_EN is defined, since that is the only
// build that instantiates it.
`ifdef STALL_PERF_CNT_EN
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // Count enabled cycles, sticking at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use and load-branch bubbles,
// mul/div EX occupancy, and IF squash on ID-resolved redirects.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CNT_W = MD_CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_use,
  input  logic                load_branch,
  input  logic                redirect,
  input  logic                md_start,
  input  logic [MD_CNT_W-1:0] md_cycles,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                idex_write,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_flush,
  output logic                busy
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
`endif
);

  stall_state_t        r_state;
  stall_state_t        w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;

  // State and mul/div countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Next state and stage controls; reset holds the RUN defaults on the outputs.
  // The md_start cycle is the first stall cycle, so MD_WAIT lasts until the
  // countdown would reach zero, giving md_cycles-1 stall cycles for md_cycles>=3.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (md_start && (md_cycles >= MD_CNT_W'(2))) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_flush  = 1'b1;
            w_md_cnt_nxt = md_cycles - MD_CNT_W'(2);
            w_state_nxt  = MD_WAIT;
          end else if (load_branch) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            w_state_nxt = LSTALL;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (redirect) begin
            ifid_flush = 1'b1;
          end
        end
        LSTALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_flush  = 1'b1;
          w_state_nxt = RUN;
        end
        MD_WAIT: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_flush  = 1'b1;
          w_md_cnt_nxt = (r_md_cnt == '0) ? '0 : r_md_cnt - MD_CNT_W'(1);
          if (w_md_cnt_nxt == '0) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt  = RUN;
          w_md_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign busy = (r_state != RUN);

`ifdef STALL_PERF_CNT_EN
  sat_counter32 u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (!pc_write),
    .o_count (stall_cycles)
  );

  sat_counter32 u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (ifid_flush),
    .o_count (flush_count)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with an expected-output queue.
module tb_pipe_stall_ctrl;

  logic       clk;
  logic       reset;
  logic       load_use;
  logic       load_branch;
  logic       redirect;
  logic       md_start;
  logic [5:0] md_cycles;
  logic       pc_write, ifid_write, idex_write;
  logic       ifid_flush, idex_flush, exmem_flush, busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];
  logic [6:0] w_obs;

  // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, busy}
  localparam logic [6:0] O_RUN   = 7'b111_000_0;
  localparam logic [6:0] O_REDIR = 7'b111_100_0;
  localparam logic [6:0] O_LD    = 7'b001_010_0;
  localparam logic [6:0] O_LST   = 7'b001_010_1;
  localparam logic [6:0] O_MD0   = 7'b000_001_0;
  localparam logic [6:0] O_MDW   = 7'b000_001_1;

  assign w_obs = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, busy};

  pipe_stall_ctrl #(.MD_CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_use    (load_use),
    .load_branch (load_branch),
    .redirect    (redirect),
    .md_start    (md_start),
    .md_cycles   (md_cycles),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_write  (idex_write),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .busy        (busy)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [6:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [6:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (w_obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, w_obs, e);
    end
    if (!reset) begin
      if (e[6] == 1'b0) exp_stall++;
      if (e[3] == 1'b1) exp_flush++;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check outputs.
  task automatic step(input string tag, input logic lu, input logic lb, input logic rd,
                      input logic ms, input logic [5:0] mc, input logic [6:0] e);
    @(negedge clk);
    load_use    = lu;
    load_branch = lb;
    redirect    = rd;
    md_start    = ms;
    md_cycles   = mc;
    push_exp(tag, e);
    #1 check_out();
  endtask

  task automatic check_perf(input string tag);
`ifdef STALL_PERF_CNT_EN
    checks++;
    assert (stall_cycles === 32'(exp_stall)) else begin
      failures++;
      $error("FAIL %s_stall observed=%0d expected=%0d", tag, stall_cycles, exp_stall);
    end
    checks++;
    assert (flush_count === 32'(exp_flush)) else begin
      failures++;
      $error("FAIL %s_flush observed=%0d expected=%0d", tag, flush_count, exp_flush);
    end
`else
    if (tag.len() == 0) $display("perf counters not built");
`endif
  endtask

  initial begin
    // Reset with a request active: outputs must still show RUN defaults.
    reset = 1'b1; load_use = 1'b1; load_branch = 1'b0; redirect = 1'b0;
    md_start = 1'b0; md_cycles = '0;
    #3;
    push_exp("reset_defaults", O_RUN);
    check_out();
    check_perf("reset");
    @(negedge clk); @(negedge clk);
    load_use = 1'b0;
    reset = 1'b0;

    step("idle0",        0, 0, 0, 0, 6'd0, O_RUN);
    step("load_use",     1, 0, 0, 0, 6'd0, O_LD);
    step("after_lu",     0, 0, 0, 0, 6'd0, O_RUN);
    step("lb_first",     0, 1, 0, 0, 6'd0, O_LD);
    step("lb_second",    1, 0, 1, 0, 6'd0, O_LST);
    step("after_lb",     0, 0, 0, 0, 6'd0, O_RUN);
    step("redir_lu",     1, 0, 1, 0, 6'd0, O_LD);
    step("redir_alone",  0, 0, 1, 0, 6'd0, O_REDIR);
    step("redir_lb",     0, 1, 1, 0, 6'd0, O_LD);
    step("lstall_redir", 0, 0, 1, 0, 6'd0, O_LST);
    step("idle1",        0, 0, 0, 0, 6'd0, O_RUN);

    // md_cycles=5: four stall cycles, requests ignored while waiting.
    step("md5_start",    0, 0, 0, 1, 6'd5, O_MD0);
    step("md5_w1",       0, 1, 1, 0, 6'd0, O_MDW);
    step("md5_w2",       1, 0, 1, 1, 6'd9, O_MDW);
    step("md5_w3",       0, 0, 0, 0, 6'd0, O_MDW);
    step("md5_done",     0, 0, 0, 0, 6'd0, O_RUN);
    step("md1_nowait",   0, 0, 0, 1, 6'd1, O_RUN);
    step("md0_nowait",   0, 0, 0, 1, 6'd0, O_RUN);
    step("md0_after",    0, 0, 0, 0, 6'd0, O_RUN);
    check_perf("mid");

    // md_start outranks load_branch; md_cycles=3 gives two stall cycles.
    step("md3_lb",       0, 1, 1, 1, 6'd3, O_MD0);
    step("md3_w1",       0, 0, 0, 0, 6'd0, O_MDW);
    step("md3_done",     0, 0, 0, 0, 6'd0, O_RUN);

    // Reset during the second MD_WAIT cycle of md_cycles=10.
    step("md10_start",   0, 0, 0, 1, 6'd10, O_MD0);
    step("md10_w1",      0, 0, 0, 0, 6'd0, O_MDW);
    step("md10_w2",      0, 0, 0, 0, 6'd0, O_MDW);
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    push_exp("md_reset_async", O_RUN);
    check_out();
    check_perf("md_reset");
    @(negedge clk);
    reset = 1'b0;
    step("post_md_reset", 0, 0, 0, 0, 6'd0, O_RUN);
    step("post_md_reset2",0, 0, 0, 0, 6'd0, O_RUN);

    // Reset during LSTALL abandons the second bubble.
    step("lb_pre_reset", 0, 1, 0, 0, 6'd0, O_LD);
    @(negedge clk);
    load_branch = 1'b0;
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    push_exp("lstall_reset", O_RUN);
    check_out();
    @(negedge clk);
    reset = 1'b0;
    step("post_ls_reset", 0, 0, 0, 0, 6'd0, O_RUN);
    step("final_redir",   0, 0, 1, 0, 6'd0, O_REDIR);
    step("final_lu",      1, 0, 0, 0, 6'd0, O_LD);
    step("final_idle",    0, 0, 0, 0, 6'd0, O_RUN);
    check_perf("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
